aes_cipher_core: RTL and testbench

- Iterative AES encryption datapath. Sits directly downstream of the combinational key-expansion block and consumes its flat expanded-key bus.
- Processes one 128-bit plaintext block per transaction and runs one AES round per clock.
- Uses a start/busy/done handshake toward the controlling logic.
- Supports AES-128, AES-192 and AES-256 through the NK parameter, matching the key-expansion block.

---
 rtl/aes_cipher_core.sv | 151 +++++++++++++++
 tb/tb_aes_cipher_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core.sv
// Iterative AES encryption datapath: one round per clock, round keys taken from the flat
// expanded-key bus produced by the key-expansion block. start/busy/done handshake.
module aes_cipher_core #(
    parameter int NK = 4,
    localparam int NR = NK + 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [0:127]          in,
    input  logic [0:128*(NR+1)-1] GeneratedKey,
    output logic                  busy,
    output logic                  done,
    output logic [0:127]          out
);
    localparam int RW = $clog2(NR + 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Forward S-box, entry x at bits [8x +: 8].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows together; byte r+4c is row r, column c.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[8*(r+4*c) +: 8] = sub_byte(s[8*(r + 4*((c + r) % 4)) +: 8]);
            end
        end
        return t;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] t;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c + 8 +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            t[32*c +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            t[32*c + 8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            t[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            t[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return t;
    endfunction

    logic [1:0]    fsm_q, fsm_d;
    logic [RW-1:0] round_q, round_d;
    logic [0:127]  state_q, state_d;
    logic [0:127]  out_q, out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [0:127]  round_key;
    logic [0:127]  sr_state;

    assign round_key = GeneratedKey[128*round_q +: 128];
    assign sr_state  = sub_shift(state_q);

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (fsm_q)
            // DONE behaves like IDLE so a start in the done cycle is taken immediately.
            IDLE, DONE: begin
                fsm_d = IDLE;
                if (start) begin
                    state_d = in ^ GeneratedKey[0:127];
                    round_d = RW'(1);
                    busy_d  = 1'b1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (round_q < LAST_ROUND) begin
                    state_d = mix_columns(sr_state) ^ round_key;
                    round_d = round_q + 1'b1;
                end else begin
                    out_d   = sr_state ^ round_key;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    round_d = '0;
                    fsm_d   = DONE;
                end
            end
            default: begin
                fsm_d  = IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            state_q <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed bench for aes_cipher_core: FIPS-197 vectors for AES-128/192/256 plus handshake,
// back-to-back, ignored-start, mid-operation reset and idle-hold cases.
module tb_aes_cipher_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [2:0]         start_v;
    logic [0:127]       din;
    logic [0:128*11-1]  gk0;
    logic [0:128*13-1]  gk1;
    logic [0:128*15-1]  gk2;
    logic               busy0, busy1, busy2;
    logic               done0, done1, done2;
    logic [0:127]       out0, out1, out2;

    logic [0:1919]      tmp;
    logic [0:128*11-1]  gk_b, gk_c;
    logic [0:127]       ct;
    int                 lat, bcnt, cnt_done, cnt_busy, cnt_chg;
    int                 n_pass = 0;
    int                 n_checks = 0;

    localparam logic [0:127] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] PT_C = 128'h00112233445566778899aabbccddeeff;

    aes_cipher_core #(.NK(4)) u_aes128 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in(din), .GeneratedKey(gk0),
        .busy(busy0), .done(done0), .out(out0)
    );
    aes_cipher_core #(.NK(6)) u_aes192 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in(din), .GeneratedKey(gk1),
        .busy(busy1), .done(done1), .out(out1)
    );
    aes_cipher_core #(.NK(8)) u_aes256 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in(din), .GeneratedKey(gk2),
        .busy(busy2), .done(done2), .out(out2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference S-box derived from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        repeat (254) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand(input logic [0:255] key, input int nk, output logic [0:1919] gk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        gk = '0;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) gk[32*i +: 32] = w[i];
    endtask

    function automatic logic get_done(input int d);
        case (d)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [0:127] get_out(input int d);
        case (d)
            0: return out0;
            1: return out1;
            default: return out2;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a block on DUT d; lat counts edges from the accepting edge up to done.
    task automatic run(input int d, input logic [0:127] pt, output logic [0:127] res,
                       output int l, output int b);
        din = pt;
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        l = 1;
        b = 0;
        while (!get_done(d) && l < 60) begin
            if (get_busy(d)) b++;
            tick();
            l++;
        end
        res = get_out(d);
    endtask

    initial begin
        rst = 1'b1;
        start_v = '0;
        din = '0;
        expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, tmp);
        gk_b = tmp[0:128*11-1];
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, tmp);
        gk_c = tmp[0:128*11-1];
        expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, tmp);
        gk1 = tmp[0:128*13-1];
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, tmp);
        gk2 = tmp;
        gk0 = gk_b;

        tick();
        tick();
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        check("reset_out", out0, 0);

        // rst has priority over start in the same cycle
        din = PT_B;
        start_v[0] = 1'b1;
        tick();
        rst = 1'b0;
        start_v[0] = 1'b0;
        tick();
        check("rst_start_busy", busy0, 0);

        // AES-128 FIPS-197 appendix B
        run(0, PT_B, ct, lat, bcnt);
        check("aes128_b_out", ct, CT_B);
        check("aes128_b_latency", lat, 11);
        check("aes128_b_busy_cycles", bcnt, 10);
        check("aes128_b_done_flag", done0, 1);
        tick();
        check("aes128_b_done_pulse", done0, 0);
        check("aes128_b_idle_busy", busy0, 0);

        // AES-128 appendix C.1, then back-to-back start in the done cycle
        gk0 = gk_c;
        run(0, PT_C, ct, lat, bcnt);
        check("aes128_c_out", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("aes128_c_latency", lat, 11);
        din = PT_C;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check("b2b_accept_busy", busy0, 1);
        check("b2b_accept_done", done0, 0);
        tick();
        tick();
        tick();
        check("b2b_out_held", out0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        lat = 4;
        while (!done0 && lat < 60) begin
            tick();
            lat++;
        end
        check("b2b_latency", lat, 11);
        check("b2b_out", out0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        tick();

        // AES-192 and AES-256
        run(1, PT_C, ct, lat, bcnt);
        check("aes192_out", ct, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        check("aes192_latency", lat, 13);
        run(2, PT_C, ct, lat, bcnt);
        check("aes256_out", ct, 128'h8ea2b7ca516745bfeafc49904b496089);
        check("aes256_latency", lat, 15);
        tick();

        // start pulses while busy are ignored
        gk0 = gk_b;
        din = PT_B;
        start_v[0] = 1'b1;
        tick();
        cnt_done = 0;
        ct = '0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3 || k == 7) begin
                din = 128'hffeeddccbbaa99887766554433221100;
                start_v[0] = 1'b1;
            end else begin
                start_v[0] = 1'b0;
            end
            tick();
            if (done0) begin
                cnt_done++;
                ct = out0;
            end
        end
        start_v[0] = 1'b0;
        check("ignore_start_done_count", cnt_done, 1);
        check("ignore_start_out", ct, CT_B);

        // reset in the middle of a block
        din = PT_B;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy0, 0);
        check("midrst_done", done0, 0);
        check("midrst_out", out0, 0);
        cnt_done = 0;
        repeat (20) begin
            tick();
            if (done0) cnt_done++;
        end
        check("midrst_no_done", cnt_done, 0);
        run(0, PT_B, ct, lat, bcnt);
        check("midrst_fresh_out", ct, CT_B);

        // idle hold after a completed block
        tick();
        cnt_done = 0;
        cnt_busy = 0;
        cnt_chg = 0;
        repeat (20) begin
            tick();
            if (done0) cnt_done++;
            if (busy0) cnt_busy++;
            if (out0 !== CT_B) cnt_chg++;
        end
        check("idle_done_count", cnt_done, 0);
        check("idle_busy_count", cnt_busy, 0);
        check("idle_out_changes", cnt_chg, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
